// File: rtl/udp_rx_parser.sv
// rtl/udp_rx_parser.sv - Ethernet/IPv4/UDP header check and 16-bit payload realignment
module udp_rx_parser #(
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [31:0] in_tdata,
  input  logic        in_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [31:0] out_tdata,
  output logic [3:0]  out_tkeep,
  output logic        out_tlast,
  output logic [15:0] out_src_port,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam logic [1:0] HDR   = 2'd0;
  localparam logic [1:0] PAY   = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        hdr_ok;
  logic [15:0] hold;
  logic        hold_vld;

  logic in_fire;
  logic out_free;
  logic dst_pass;
  logic load_pay;
  logic load_flush;

  assign in_fire    = in_tvalid && in_tready;
  assign out_free   = !out_tvalid || out_tready;
  // hdr_ok already folds in the EtherType, IHL/version and protocol checks
  assign dst_pass   = hdr_ok && (in_tdata[31:16] == UDP_PORT);
  // First payload word (w10) only primes the hold register
  assign load_pay   = (state == PAY) && in_fire && hold_vld;
  assign load_flush = (state == FLUSH) && out_free;

  // Input backpressure: headers and dropped frames always drain, payload follows the output register
  always_comb begin
    in_tready = 1'b0;
    case (state)
      HDR:     in_tready = 1'b1;
      DROP:    in_tready = 1'b1;
      PAY:     in_tready = out_free;
      default: in_tready = 1'b0;
    endcase
  end

  // Frame-level state, header checks, hold register and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HDR;
      cnt            <= 4'd0;
      hdr_ok         <= 1'b0;
      hold           <= 16'h0000;
      hold_vld       <= 1'b0;
      out_src_port   <= 16'h0000;
      frames_ok      <= 16'h0000;
      frames_dropped <= 16'h0000;
    end else begin
      case (state)
        HDR: begin
          if (in_fire) begin
            if (cnt == 4'd3) hdr_ok <= (in_tdata[31:16] == 16'h0800) && (in_tdata[15:8] == 8'h45);
            if (cnt == 4'd5) hdr_ok <= hdr_ok && (in_tdata[7:0] == 8'h11);
            if (cnt == 4'd8) out_src_port <= in_tdata[15:0];
            if (in_tlast) begin
              frames_dropped <= frames_dropped + 16'd1;
              cnt            <= 4'd0;
            end else if (cnt == 4'd9) begin
              cnt      <= 4'd10;
              hold_vld <= 1'b0;
              state    <= dst_pass ? PAY : DROP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        PAY: begin
          if (in_fire) begin
            hold     <= in_tdata[15:0];
            hold_vld <= 1'b1;
            if (in_tlast) state <= FLUSH;
          end
        end
        DROP: begin
          if (in_fire && in_tlast) begin
            frames_dropped <= frames_dropped + 16'd1;
            cnt            <= 4'd0;
            state          <= HDR;
          end
        end
        default: begin
          if (out_free) begin
            frames_ok <= frames_ok + 16'd1;
            cnt       <= 4'd0;
            state     <= HDR;
          end
        end
      endcase
    end
  end

  // Single-stage output register; a new load may coincide with the downstream transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= 32'h0;
      out_tkeep  <= 4'h0;
      out_tlast  <= 1'b0;
    end else if (load_pay) begin
      out_tvalid <= 1'b1;
      out_tdata  <= {hold, in_tdata[31:16]};
      out_tkeep  <= 4'b1111;
      out_tlast  <= 1'b0;
    end else if (load_flush) begin
      out_tvalid <= 1'b1;
      out_tdata  <= {hold, 16'h0000};
      out_tkeep  <= 4'b1100;
      out_tlast  <= 1'b1;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// tb/tb_udp_rx_parser.sv - directed frames checked against a byte-level payload model
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [31:0] in_tdata = 32'h0;
  logic        in_tlast = 1'b0;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [31:0] out_tdata;
  logic [3:0]  out_tkeep;
  logic        out_tlast;
  logic [15:0] out_src_port;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  udp_rx_parser #(.UDP_PORT(16'd5000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_src_port(out_src_port), .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] frm[$];
  logic [37:0] exp_q[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_keep[$];
  logic        obs_last[$];
  logic [15:0] m_ok = 16'd0;
  logic [15:0] m_drop = 16'd0;
  logic [15:0] m_src = 16'd0;
  bit          cur_acc = 1'b0;
  bit          stall_mode = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic build(int len, logic [15:0] etype, logic [7:0] proto, logic [15:0] dport,
                       logic [15:0] sport, logic [7:0] seed);
    frm.delete();
    for (int k = 0; k < len; k++) begin
      logic [31:0] w;
      case (k)
        0: w = {8'h02, seed, 16'h0001};
        1: w = 32'h00000A0B;
        2: w = 32'h0C0D0E0F;
        3: w = {etype, 8'h45, 8'h00};
        4: w = 32'h00301234;
        5: w = {16'h4000, 8'h40, proto};
        6: w = 32'h0A000001;
        7: w = 32'h0A000002;
        8: w = {16'h0203, sport};
        9: w = {dport, 16'h0020};
        default: w = {seed, 8'(k), 8'(~seed), 8'(k * 7 + 1)};
      endcase
      frm.push_back(w);
    end
  endtask

  // Model: decide acceptance from header fields, then slice payload bytes (from byte 42) into words
  task automatic model_frame();
    int len;
    byte unsigned b[$];
    len = frm.size();
    if (len >= 9) m_src = frm[8][15:0];
    cur_acc = (len >= 11) && (frm[3][31:16] == 16'h0800) && (frm[3][15:8] == 8'h45) &&
              (frm[5][7:0] == 8'h11) && (frm[9][31:16] == 16'd5000);
    if (!cur_acc) begin
      m_drop = m_drop + 16'd1;
    end else begin
      for (int i = 0; i < len; i++) begin
        logic [31:0] w;
        w = frm[i];
        for (int j = 3; j >= 0; j--) b.push_back(w[8*j +: 8]);
      end
      for (int i = 0; i < 42; i++) void'(b.pop_front());
      while (b.size() > 0) begin
        int n;
        logic [31:0] d;
        logic [3:0] kp;
        n = (b.size() >= 4) ? 4 : b.size();
        d = 32'h0;
        kp = 4'h0;
        for (int j = 0; j < 4; j++) begin
          d  = {d[23:0], (j < n) ? b[j] : 8'h00};
          kp = {kp[2:0], (j < n)};
        end
        for (int j = 0; j < n; j++) void'(b.pop_front());
        exp_q.push_back({1'b1, (b.size() == 0), kp, d});
      end
      m_ok = m_ok + 16'd1;
    end
  endtask

  task automatic send(int nsend);
    for (int i = 0; i < nsend; i++) begin
      int t;
      t = 0;
      in_tvalid = 1'b1;
      in_tdata  = frm[i];
      in_tlast  = (i == frm.size() - 1);
      @(negedge clk);
      while (!in_tready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_tready) chk("in_tready_timeout", in_tready, 1);
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_tvalid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
    chk("frames_ok", frames_ok, m_ok);
    chk("frames_dropped", frames_dropped, m_drop);
    chk("src_port", out_src_port, m_src);
  endtask

  task automatic run_frame();
    model_frame();
    send(frm.size());
    drain();
    check_stats();
  endtask

  // Downstream ready: always 1, or random stalls when stall_mode is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Compare process: every transfer against the model queue, stall stability, FLUSH backpressure
  initial begin
    logic [37:0] cur;
    logic [37:0] prev_out;
    logic [37:0] e;
    bit prev_stall;
    bit flushing;
    prev_stall = 1'b0;
    flushing = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        flushing = 1'b0;
        continue;
      end
      cur = {out_tvalid, out_tlast, out_tkeep, out_tdata};
      if (prev_stall) chk("stall_stable", cur, prev_out);
      if (flushing && !(out_tvalid && out_tlast)) chk("flush_in_tready", in_tready, 0);
      if (out_tvalid && out_tlast) flushing = 1'b0;
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", cur, e);
          obs_data.push_back(out_tdata);
          obs_keep.push_back(out_tkeep);
          obs_last.push_back(out_tlast);
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_out = cur;
      if (in_tvalid && in_tready && in_tlast && cur_acc) flushing = 1'b1;
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tkeep", out_tkeep, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_src_port", out_src_port, 0);
    chk("rst_frames_ok", frames_ok, 0);
    chk("rst_frames_dropped", frames_dropped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Valid 12-word frame, hand-computed payload
    obs_data.delete(); obs_keep.delete(); obs_last.delete();
    build(12, 16'h0800, 8'h11, 16'd5000, 16'd1234, 8'h10);
    frm[10] = 32'h0000AABB;
    frm[11] = 32'hCCDDEEFF;
    run_frame();
    chk("t1_count", obs_data.size(), 2);
    if (obs_data.size() == 2) begin
      chk("t1_w0_data", obs_data[0], 32'hAABBCCDD);
      chk("t1_w0_keep", obs_keep[0], 4'hF);
      chk("t1_w0_last", obs_last[0], 0);
      chk("t1_w1_data", obs_data[1], 32'hEEFF0000);
      chk("t1_w1_keep", obs_keep[1], 4'hC);
      chk("t1_w1_last", obs_last[1], 1);
    end
    chk("t1_src_lit", out_src_port, 16'd1234);
    chk("t1_ok_lit", frames_ok, 16'd1);

    // Header rejections, each followed by a valid frame
    obs_data.delete();
    build(14, 16'h86DD, 8'h11, 16'd5000, 16'd100, 8'h21);
    run_frame();
    chk("t2_drop_lit", frames_dropped, 16'd1);
    chk("t2_no_out", obs_data.size(), 0);
    build(13, 16'h0800, 8'h11, 16'd5000, 16'd101, 8'h22);
    run_frame();
    build(13, 16'h0800, 8'h06, 16'd5000, 16'd102, 8'h23);
    run_frame();
    build(13, 16'h0800, 8'h11, 16'd5000, 16'd103, 8'h24);
    run_frame();
    build(13, 16'h0800, 8'h11, 16'd5001, 16'd104, 8'h25);
    run_frame();
    build(15, 16'h0800, 8'h11, 16'd5000, 16'd105, 8'h26);
    run_frame();
    chk("t2_ok_lit", frames_ok, 16'd4);
    chk("t2_drop3_lit", frames_dropped, 16'd3);

    // Early tlast on w6, back-to-back with a valid frame
    build(7, 16'h0800, 8'h11, 16'd5000, 16'd200, 8'h31);
    model_frame();
    send(frm.size());
    build(12, 16'h0800, 8'h11, 16'd5000, 16'd201, 8'h32);
    run_frame();

    // tlast on w9 is still a drop
    build(10, 16'h0800, 8'h11, 16'd5000, 16'd300, 8'h41);
    run_frame();

    // 11-word frame: one flush word only
    obs_data.delete(); obs_keep.delete(); obs_last.delete();
    build(11, 16'h0800, 8'h11, 16'd5000, 16'd400, 8'h51);
    frm[10] = 32'h1111ABCD;
    run_frame();
    chk("t5_count", obs_data.size(), 1);
    if (obs_data.size() == 1) begin
      chk("t5_data", obs_data[0], 32'hABCD0000);
      chk("t5_keep", obs_keep[0], 4'hC);
      chk("t5_last", obs_last[0], 1);
    end

    // 20-word frame with downstream stalls
    stall_mode = 1'b1;
    build(20, 16'h0800, 8'h11, 16'd5000, 16'd500, 8'h61);
    run_frame();

    // Reset in the middle of a payload
    build(20, 16'h0800, 8'h11, 16'd5000, 16'd600, 8'h71);
    model_frame();
    send(15);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_tvalid, 0);
    chk("mid_rst_ok", frames_ok, 0);
    chk("mid_rst_drop", frames_dropped, 0);
    chk("mid_rst_src", out_src_port, 0);
    exp_q.delete();
    m_ok = 16'd0;
    m_drop = 16'd0;
    m_src = 16'd0;
    cur_acc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build(16, 16'h0800, 8'h11, 16'd5000, 16'd700, 8'h81);
    run_frame();
    chk("t7_ok_lit", frames_ok, 16'd1);
    stall_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
